// File: rtl/opn_seq_pkg.sv
// Shared types for the OPN (jt12/jt03) host-side write sequencer.
package opn_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        GAP,
        POLL
    } state_e;

    typedef struct packed {
        logic       part;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cmd_t;

    localparam logic A0_ADDR = 1'b0;
    localparam logic A0_DATA = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/opn_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, flush wins over push/pop.
module opn_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/opn_write_sequencer.sv
// Replays queued {part, reg, value} commands onto the jt12/jt03 CPU bus as
// address-write then data-write cycles, with a fixed gap or busy-flag polling.
module opn_write_sequencer
    import opn_seq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 32,
    parameter int BUSY_POLL  = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_part,
    input  logic [7:0]               cmd_reg,
    input  logic [7:0]               cmd_data,
    input  logic                     flush,
    output logic                     bus_cs_n,
    output logic                     bus_wr_n,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [7:0]               bus_dout,
    input  logic [7:0]               bus_din,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     idle,
    output logic                     timeout_err
);
    localparam int CNT_MAX = max2(max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, GAP_CYC)), TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    cmd_t                cmd_q, cmd_d;
    logic                terr_q, terr_d;
    logic                cs_n_q, cs_n_d;
    logic                wr_n_q, wr_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic [1:0]          addr_full;
    logic                cnt_zero;
    logic                fifo_full, fifo_empty, fifo_pop;
    cmd_t                push_cmd, head_cmd;
    logic                unused_din;

    assign push_cmd   = {cmd_part, cmd_reg, cmd_data};
    assign cmd_ready  = !fifo_full;
    assign unused_din = ^bus_din[6:0];

    opn_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (push_cmd),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        terr_d   = terr_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A flush in the same cycle wins: nothing new is started.
                if (!fifo_empty && !flush) begin
                    fifo_pop = 1'b1;
                    cmd_d    = head_cmd;
                    state_d  = A_SETUP;
                    cnt_d    = CW'(SETUP_CYC - 1);
                end
            end
            A_SETUP:  if (cnt_zero) begin state_d = A_STROBE; cnt_d = CW'(STROBE_CYC - 1); end
                      else cnt_d = cnt_q - CW'(1);
            A_STROBE: if (cnt_zero) begin state_d = A_HOLD;   cnt_d = CW'(HOLD_CYC - 1);   end
                      else cnt_d = cnt_q - CW'(1);
            A_HOLD:   if (cnt_zero) begin state_d = D_SETUP;  cnt_d = CW'(SETUP_CYC - 1);  end
                      else cnt_d = cnt_q - CW'(1);
            D_SETUP:  if (cnt_zero) begin state_d = D_STROBE; cnt_d = CW'(STROBE_CYC - 1); end
                      else cnt_d = cnt_q - CW'(1);
            D_STROBE: if (cnt_zero) begin state_d = D_HOLD;   cnt_d = CW'(HOLD_CYC - 1);   end
                      else cnt_d = cnt_q - CW'(1);
            D_HOLD:   if (cnt_zero) begin state_d = GAP;      cnt_d = CW'(GAP_CYC - 1);    end
                      else cnt_d = cnt_q - CW'(1);
            GAP: begin
                if (cnt_zero) begin
                    if (BUSY_POLL != 0) begin
                        state_d = POLL;
                        cnt_d   = CW'(TIMEOUT - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            POLL: begin
                if (!bus_din[7]) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register alongside it.
    always_comb begin
        cs_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        addr_d    = addr_q;
        dout_d    = dout_q;
        addr_full = '0;
        unique case (state_d)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_n_d    = 1'b0;
                wr_n_d    = (state_d != A_STROBE);
                addr_full = {cmd_d.part, A0_ADDR};
                addr_d    = addr_full[ADDR_W-1:0];
                dout_d    = cmd_d.reg_addr;
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_n_d    = 1'b0;
                wr_n_d    = (state_d != D_STROBE);
                addr_full = {cmd_d.part, A0_DATA};
                addr_d    = addr_full[ADDR_W-1:0];
                dout_d    = cmd_d.data;
            end
            POLL: begin
                cs_n_d    = 1'b0;
                addr_full = {cmd_d.part, A0_ADDR};
                addr_d    = addr_full[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            terr_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            terr_q  <= terr_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign bus_cs_n    = cs_n_q;
    assign bus_wr_n    = wr_n_q;
    assign bus_addr    = addr_q;
    assign bus_dout    = dout_q;
    assign timeout_err = terr_q;
    assign idle        = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_opn_write_sequencer.sv
// Directed bench: three sequencer instances (jt12 defaults, jt03 address width,
// busy polling) driven from one command bus with per-instance valid.
module tb_opn_write_sequencer;

    logic       clk_in    = 1'b0;
    logic       rst_n     = 1'b0;
    logic [2:0] cmd_valid = '0;
    logic       cmd_part  = 1'b0;
    logic [7:0] cmd_reg   = '0;
    logic [7:0] cmd_data  = '0;
    logic       flush     = 1'b0;
    logic       busy_c    = 1'b0;

    logic [2:0] cmd_ready, cs_n, wr_n, idle, terr;
    logic [1:0] addr_a, addr_c;
    logic [0:0] addr_b;
    logic [7:0] dout_a, dout_b, dout_c;
    logic [4:0] level_a, level_b, level_c;
    logic [7:0] din_c;

    int checks   = 0;
    int failures = 0;
    int low_a    = 0;
    logic [9:0] log_a[$];
    logic [9:0] log_b[$];
    logic [9:0] log_c[$];
    logic [2:0] wr_prev = 3'b111;

    always #5 clk_in = ~clk_in;
    assign din_c = {busy_c, 7'h00};

    opn_write_sequencer dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_data(cmd_data), .flush(flush),
        .bus_cs_n(cs_n[0]), .bus_wr_n(wr_n[0]), .bus_addr(addr_a), .bus_dout(dout_a),
        .bus_din(8'h00), .level(level_a), .idle(idle[0]), .timeout_err(terr[0])
    );

    opn_write_sequencer #(.ADDR_W(1)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_data(cmd_data), .flush(flush),
        .bus_cs_n(cs_n[1]), .bus_wr_n(wr_n[1]), .bus_addr(addr_b), .bus_dout(dout_b),
        .bus_din(8'h00), .level(level_b), .idle(idle[1]), .timeout_err(terr[1])
    );

    opn_write_sequencer #(.GAP_CYC(4), .BUSY_POLL(1)) dut_c (
        .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_data(cmd_data), .flush(flush),
        .bus_cs_n(cs_n[2]), .bus_wr_n(wr_n[2]), .bus_addr(addr_c), .bus_dout(dout_c),
        .bus_din(din_c), .level(level_c), .idle(idle[2]), .timeout_err(terr[2])
    );

    // One line per write strobe, logged as {addr, dout} at the falling edge of wr_n.
    always @(negedge clk_in) begin
        if (!wr_n[0] && wr_prev[0]) begin
            log_a.push_back({addr_a, dout_a});
            $display("dut_a write addr=%0d dout=%02h", addr_a, dout_a);
        end
        if (!wr_n[1] && wr_prev[1]) begin
            log_b.push_back({1'b0, addr_b, dout_b});
            $display("dut_b write addr=%0d dout=%02h", addr_b, dout_b);
        end
        if (!wr_n[2] && wr_prev[2]) begin
            log_c.push_back({addr_c, dout_c});
            $display("dut_c write addr=%0d dout=%02h", addr_c, dout_c);
        end
        if (wr_n[0] === 1'b0) low_a++;
        wr_prev = wr_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int which, input logic p, input logic [7:0] r, input logic [7:0] d);
        cmd_part         = p;
        cmd_reg          = r;
        cmd_data         = d;
        cmd_valid        = 3'b000;
        cmd_valid[which] = 1'b1;
        @(negedge clk_in);
        cmd_valid = 3'b000;
    endtask

    task automatic wait_idle(input int which, input int bound, output int cyc);
        cyc = 0;
        while (!idle[which] && cyc < bound) begin
            @(negedge clk_in);
            cyc++;
        end
    endtask

    // Runs one write on dut_c with busy asserted; busy drops after release_at POLL cycles (0 = never).
    task automatic poll_run(input int release_at, output int pc);
        int n;
        busy_c = 1'b1;
        log_c.delete();
        push(2, 1'b1, 8'hB0, 8'h01);
        n = 0;
        while (log_c.size() < 2 && n < 60) begin @(negedge clk_in); n++; end
        while (cs_n[2] == 1'b0 && n < 60) begin @(negedge clk_in); n++; end
        while (cs_n[2] == 1'b1 && n < 60) begin @(negedge clk_in); n++; end
        check_eq("poll_enter_bound", n < 60, 1);
        check_eq("poll_addr", addr_c, 2'd2);
        check_eq("poll_wr_n", wr_n[2], 1'b1);
        pc = 0;
        while (cs_n[2] == 1'b0 && pc < 5000) begin
            pc++;
            if (pc == release_at) busy_c = 1'b0;
            @(negedge clk_in);
        end
        busy_c = 1'b0;
    endtask

    initial begin
        int n;
        int pc;

        // Reset state
        repeat (4) @(negedge clk_in);
        check_eq("rst_cs_n", cs_n[0], 1'b1);
        check_eq("rst_wr_n", wr_n[0], 1'b1);
        check_eq("rst_addr", addr_a, 2'd0);
        check_eq("rst_dout", dout_a, 8'h00);
        check_eq("rst_ready", cmd_ready[0], 1'b1);
        check_eq("rst_level", level_a, 5'd0);
        check_eq("rst_idle", idle[0], 1'b1);
        check_eq("rst_terr", terr[2], 1'b0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Single write: pop cycle + 2*(1+2+1) + 32 gap = 41 cycles to idle
        log_a.delete();
        low_a = 0;
        push(0, 1'b0, 8'h28, 8'h10);
        wait_idle(0, 100, n);
        check_eq("single_latency", n, 41);
        check_eq("single_low_cycles", low_a, 4);
        check_eq("single_count", log_a.size(), 2);
        check_eq("single_addr_phase", log_a[0], 10'h028);
        check_eq("single_data_phase", log_a[1], 10'h110);

        // Part select: jt12 uses {part,a0}, jt03 ignores part
        log_a.delete();
        push(0, 1'b1, 8'hA4, 8'h24);
        wait_idle(0, 100, n);
        check_eq("part_a_count", log_a.size(), 2);
        check_eq("part_a_addr_phase", log_a[0], 10'h2A4);
        check_eq("part_a_data_phase", log_a[1], 10'h324);
        log_b.delete();
        push(1, 1'b1, 8'hA4, 8'h24);
        wait_idle(1, 100, n);
        check_eq("part_b_count", log_b.size(), 2);
        check_eq("part_b_addr_phase", log_b[0], 10'h0A4);
        check_eq("part_b_data_phase", log_b[1], 10'h124);

        // Fill: one command is popped right away, so 17 pushes reach level 16
        log_a.delete();
        for (int i = 0; i < 17; i++) begin
            cmd_part  = 1'b0;
            cmd_reg   = 8'h30 + 8'(i);
            cmd_data  = 8'hC0 ^ 8'(i);
            cmd_valid = 3'b001;
            @(negedge clk_in);
        end
        check_eq("fill_level", level_a, 5'd16);
        check_eq("fill_ready", cmd_ready[0], 1'b0);
        cmd_reg  = 8'hEE;
        cmd_data = 8'hEE;
        repeat (5) @(negedge clk_in);
        check_eq("full_hold_level", level_a, 5'd16);
        check_eq("full_hold_ready", cmd_ready[0], 1'b0);
        cmd_valid = 3'b000;
        wait_idle(0, 1000, n);
        check_eq("fill_drain_bound", n < 1000, 1);
        check_eq("fill_count", log_a.size(), 34);
        for (int i = 0; i < 17; i++) begin
            check_eq("fill_order_addr", log_a[2*i],   {2'b00, 8'(8'h30 + 8'(i))});
            check_eq("fill_order_data", log_a[2*i+1], {2'b01, 8'(8'hC0 ^ 8'(i))});
        end

        // Flush during the first data strobe
        log_a.delete();
        for (int i = 0; i < 5; i++) push(0, 1'b0, 8'h50 + 8'(i), 8'h60 + 8'(i));
        n = 0;
        while (log_a.size() < 2 && n < 60) begin @(negedge clk_in); n++; end
        check_eq("flush_reach_bound", n < 60, 1);
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        check_eq("flush_level", level_a, 5'd0);
        wait_idle(0, 200, n);
        repeat (60) @(negedge clk_in);
        check_eq("flush_count", log_a.size(), 2);
        check_eq("flush_addr_phase", log_a[0], 10'h050);
        check_eq("flush_data_phase", log_a[1], 10'h160);
        check_eq("flush_idle", idle[0], 1'b1);

        // Reset in the middle of a write
        log_a.delete();
        for (int i = 0; i < 3; i++) push(0, 1'b1, 8'h70 + 8'(i), 8'h80);
        n = 0;
        while (wr_n[0] == 1'b1 && n < 20) begin @(negedge clk_in); n++; end
        check_eq("midrst_reach_bound", n < 20, 1);
        rst_n = 1'b0;
        @(negedge clk_in);
        check_eq("midrst_cs_n", cs_n[0], 1'b1);
        check_eq("midrst_wr_n", wr_n[0], 1'b1);
        check_eq("midrst_level", level_a, 5'd0);
        check_eq("midrst_idle", idle[0], 1'b1);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        log_a.delete();
        repeat (100) @(negedge clk_in);
        check_eq("midrst_no_writes", log_a.size(), 0);
        check_eq("midrst_idle_after", idle[0], 1'b1);

        // Busy for 10 poll samples, then clear
        poll_run(10, pc);
        check_eq("poll10_cycles", pc, 10);
        check_eq("poll10_terr", terr[2], 1'b0);
        check_eq("poll10_idle", idle[2], 1'b1);

        // Stuck busy: 4096 poll samples then abandon
        poll_run(0, pc);
        check_eq("timeout_cycles", pc, 4096);
        check_eq("timeout_terr", terr[2], 1'b1);
        check_eq("timeout_idle", idle[2], 1'b1);
        push(2, 1'b0, 8'h28, 8'h00);
        wait_idle(2, 100, n);
        check_eq("timeout_sticky", terr[2], 1'b1);
        rst_n = 1'b0;
        @(negedge clk_in);
        check_eq("timeout_reset_clears", terr[2], 1'b0);
        rst_n = 1'b1;
        @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
